nlfsr_ring_auth: RTL and testbench
==================================

# nlfsr_ring_auth

Parametrised authentication-signature generator: N_SEG nonlinear feedback shift register segments of SEG_W bits each, chained in a ring so that each segment's output bit perturbs the next segment's feedback. The block runs for a programmable number of clock steps under a built-in cycle counter and state machine, then holds the concatenated state as the signature. It is the generalised successor of the fixed 4×32-bit authentication top. It sits between the challenge/seed interface and the signature compare logic.

## Interface
- SEG_W, 32, bits per NLFSR segment (≥ 8)
- N_SEG, 4, number of segments in the ring (≥ 2)
- CNT_W, 32, width of the cycle count
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  load seed_top into the segments
- seed_top  in  SEG_W*N_SEG  seed; segment i = seed_top[SEG_W*(N_SEG-i)-1 -: SEG_W] (segment 0 at MSBs)
- cnt_load  in  1  latch cycle into the cycle register
- cycle  in  CNT_W  number of NLFSR steps for the next run
- start_cnt  in  1  start a run (single-cycle pulse)
- ring_en  in  1  1 = ring-coupled flip bits; 0 = segments independent (flip_in forced 0)
- out_final  out  SEG_W*N_SEG  current segment state, same slicing as seed_top
- busy  out  1  high while in RUN
- cnt_done  out  1  high while in DONE

## Operation
- Segment step (s = segment state, W = SEG_W): f = s[W-1] ^ s[W/2] ^ (s[1] & s[2]) ^ flip_in; s_next = {s[W-2:0], f}; segment output bit = s[W-1].
- flip_in of segment i = output bit of segment i-1; segment 0 takes segment N_SEG-1. All segments step simultaneously using pre-step values. ring_en = 0 forces every flip_in to 0. ring_en is sampled every step.
- Zero-lock guard: any seed segment equal to all-zeros loads as 1 (LSB set). Other segments load unchanged.
- cycle register: loaded from cycle on cnt_load in any state except RUN. cnt_load in RUN is ignored.
- FSM states:
  - IDLE (reset): load → ARMED.
  - ARMED: start_cnt → RUN with down-counter = cycle register. If the cycle register is 0, go directly to DONE with no step.
  - RUN: one step per cycle, counter decrements. On the cycle the counter goes 1→0, the last step occurs and the FSM → DONE.
  - DONE: state is held. start_cnt → new run continuing from the current state (same rules as ARMED). load → ARMED.
- Priority: rst > load > start_cnt. load in RUN aborts the run, reloads the seed and goes → ARMED. start_cnt in IDLE or RUN is ignored.
- Segments change only on load or on a RUN step. They are held otherwise.

## Timing
- Reset values: out_final = 0, busy = 0, cnt_done = 0, cycle register = 0, counter = 0, FSM = IDLE.
- load at edge k: seed is visible on out_final after edge k.
- start_cnt at edge k with cycle = C > 0:
  - busy = 1 after edge k.
  - Steps occur at edges k+1 … k+C.
  - busy = 0 and cnt_done = 1 after edge k+C.
  - Total latency from start_cnt to cnt_done is C+1 cycles.
- C = 0: cnt_done = 1 after edge k, with no step.
- cnt_done stays level high in DONE. It drops on the edge that leaves DONE, either via start_cnt (→ RUN) or load.
- Counter arithmetic is unsigned CNT_W. Maximum run = 2^CNT_W − 1 steps, with no wrap.

## Test plan
- Reset then idle: out_final = 0, busy = 0, cnt_done = 0. start_cnt in IDLE → no change.
- SEG_W=32, N_SEG=4: all segments seeded 32'h0000_0001, cycle = 1, ring_en = 1, start → cnt_done two cycles after start_cnt; every segment = 32'h0000_0002.
- Seed segment 0 = 32'h8000_0000, segments 1–3 = 32'h0000_0001, cycle = 1, ring_en = 1 → segments = 0x00000001, 0x00000003, 0x00000002, 0x00000002. Same seed with ring_en = 0 → segment 1 = 0x00000002.
- Seed = 0 on all segments → out_final = {4{32'h0000_0001}}. cycle = 0, start → cnt_done next cycle, out_final unchanged.
- cycle = 100, start_cnt, then load asserted at step 40 → busy drops, cnt_done never rises, out_final = new seed. cnt_load in RUN is ignored.
- Run cycle = 10 then rerun cycle = 10 from DONE → result equals a single cycle = 20 run from the same seed; reference model compared every cycle.

Source files
------------

// File: rtl/nlfsr_ring_auth_if.sv
// rtl/nlfsr_ring_auth_if.sv - seed/control/signature bundle for nlfsr_ring_auth
// Purpose: groups the challenge/seed controls and the signature outputs.
// Signals:
//   load      seed load strobe            seed_top  concatenated seed (segment 0 at MSBs)
//   cnt_load  latch cycle into cycle reg  cycle     step count for the next run
//   start_cnt start a run                 ring_en   1 = ring-coupled flip bits
//   out_final current segment state       busy      high while running
//   cnt_done  high while the run is done
// Modports: master drives controls and observes results; slave is the generator.
interface nlfsr_ring_auth_if #(
  parameter int SEG_W = 32,
  parameter int N_SEG = 4,
  parameter int CNT_W = 32
);
  logic                   load;
  logic [SEG_W*N_SEG-1:0] seed_top;
  logic                   cnt_load;
  logic [CNT_W-1:0]       cycle;
  logic                   start_cnt;
  logic                   ring_en;
  logic [SEG_W*N_SEG-1:0] out_final;
  logic                   busy;
  logic                   cnt_done;

  modport master (
    output load, seed_top, cnt_load, cycle, start_cnt, ring_en,
    input  out_final, busy, cnt_done
  );

  modport slave (
    input  load, seed_top, cnt_load, cycle, start_cnt, ring_en,
    output out_final, busy, cnt_done
  );
endinterface

// File: rtl/nlfsr_ring_auth.sv
// rtl/nlfsr_ring_auth.sv - ring of NLFSR segments producing an authentication signature
// Purpose: N_SEG nonlinear shift-register segments, each segment's MSB perturbing the
//   next segment's feedback, stepped for a programmed number of cycles then held.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    nlfsr_ring_auth_if.slave (load/seed_top/cnt_load/cycle/start_cnt/ring_en in,
//          out_final/busy/cnt_done out)
module nlfsr_ring_auth #(
  parameter int SEG_W = 32,
  parameter int N_SEG = 4,
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  nlfsr_ring_auth_if.slave   bus
);
  localparam int TOT_W = SEG_W * N_SEG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_step;

  logic [SEG_W-1:0] r_seg      [N_SEG];
  logic [SEG_W-1:0] w_seg_step [N_SEG];
  logic [SEG_W-1:0] w_seg_seed [N_SEG];
  logic [TOT_W-1:0] w_out_final;

  // Per-segment feedback and seed conditioning. All segments read pre-step state.
  for (genvar gi = 0; gi < N_SEG; gi++) begin : g_seg
    localparam int PREV = (gi == 0) ? (N_SEG - 1) : (gi - 1);
    logic             w_flip;
    logic             w_fb;
    logic [SEG_W-1:0] w_raw;

    assign w_flip = bus.ring_en & r_seg[PREV][SEG_W-1];
    assign w_fb   = r_seg[gi][SEG_W-1] ^ r_seg[gi][SEG_W/2]
                  ^ (r_seg[gi][1] & r_seg[gi][2]) ^ w_flip;
    assign w_seg_step[gi] = {r_seg[gi][SEG_W-2:0], w_fb};

    // An all-zero segment would be stuck forever without ring help; force LSB.
    assign w_raw = bus.seed_top[SEG_W*(N_SEG-gi)-1 -: SEG_W];
    assign w_seg_seed[gi] = (w_raw == '0) ? {{(SEG_W-1){1'b0}}, 1'b1} : w_raw;
  end

  always_comb begin
    w_out_final = '0;
    for (int i = 0; i < N_SEG; i++) begin
      w_out_final[SEG_W*(N_SEG-i)-1 -: SEG_W] = r_seg[i];
    end
  end

  assign bus.out_final = w_out_final;
  assign bus.busy      = (r_state == S_RUN);
  assign bus.cnt_done  = (r_state == S_DONE);

  // Next-state logic. load outranks everything except reset.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_step       = 1'b0;
    if (bus.load) begin
      w_state_next = S_ARMED;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_IDLE;
        end
        S_ARMED, S_DONE: begin
          if (bus.start_cnt) begin
            if (r_cycle == '0) begin
              w_state_next = S_DONE;
              w_cnt_next   = '0;
            end else begin
              w_state_next = S_RUN;
              w_cnt_next   = r_cycle;
            end
          end
        end
        S_RUN: begin
          w_step     = 1'b1;
          w_cnt_next = r_cnt - CNT_W'(1);
          // The counter reaching zero marks the final step of this run.
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = S_DONE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cycle <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < N_SEG; i++) begin
        r_seg[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // The run length is frozen while a run is in flight.
      if (bus.cnt_load && (r_state != S_RUN)) begin
        r_cycle <= bus.cycle;
      end
      for (int i = 0; i < N_SEG; i++) begin
        if (bus.load) begin
          r_seg[i] <= w_seg_seed[i];
        end else if (w_step) begin
          r_seg[i] <= w_seg_step[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_nlfsr_ring_auth.sv
// tb/tb_nlfsr_ring_auth.sv - self-checking bench for nlfsr_ring_auth
module tb_nlfsr_ring_auth;
  localparam int SEG_W = 32;
  localparam int N_SEG = 4;
  localparam int CNT_W = 32;
  localparam int TOT   = SEG_W * N_SEG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nlfsr_ring_auth_if #(.SEG_W(SEG_W), .N_SEG(N_SEG), .CNT_W(CNT_W)) bus ();

  nlfsr_ring_auth #(.SEG_W(SEG_W), .N_SEG(N_SEG), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [TOT-1:0] model;
  logic [TOT-1:0] seed_a;
  logic [TOT-1:0] seed_b;
  logic [TOT-1:0] res_split;

  // Whole-ring step: each segment shifts left, appending its feedback bit,
  // where the flip term is the previous segment's top bit (ring wraps).
  function automatic logic [TOT-1:0] ring_step(input logic [TOT-1:0] st, input bit ren);
    logic [SEG_W-1:0] s [N_SEG];
    logic [TOT-1:0]   r;
    logic             fb;
    for (int i = 0; i < N_SEG; i++) s[i] = st[SEG_W*(N_SEG-i)-1 -: SEG_W];
    r = '0;
    for (int i = 0; i < N_SEG; i++) begin
      fb = s[i][SEG_W-1] ^ s[i][SEG_W/2] ^ (s[i][1] & s[i][2])
         ^ (ren & s[(i + N_SEG - 1) % N_SEG][SEG_W-1]);
      r[SEG_W*(N_SEG-i)-1 -: SEG_W] = (s[i] << 1) | SEG_W'(fb);
    end
    return r;
  endfunction

  function automatic logic [TOT-1:0] seed_val(input logic [TOT-1:0] sd);
    logic [TOT-1:0]   r;
    logic [SEG_W-1:0] s;
    r = sd;
    for (int i = 0; i < N_SEG; i++) begin
      s = sd[SEG_W*(N_SEG-i)-1 -: SEG_W];
      if (s == 0) r[SEG_W*(N_SEG-i)-1 -: SEG_W] = SEG_W'(1);
    end
    return r;
  endfunction

  function automatic logic [TOT-1:0] rand_seed();
    logic [TOT-1:0] r;
    for (int i = 0; i < TOT / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [TOT-1:0] obs, input logic [TOT-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [TOT-1:0] sd);
    bus.seed_top = sd;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    model = seed_val(sd);
    check("load_out", bus.out_final, model);
  endtask

  task automatic set_cycle(input int unsigned c);
    bus.cycle = CNT_W'(c);
    bus.cnt_load = 1'b1;
    tick();
    bus.cnt_load = 1'b0;
  endtask

  // Start a run of c steps and compare every cycle against the model.
  task automatic run(input int unsigned c, input bit rand_ren);
    bit ren;
    bus.start_cnt = 1'b1;
    tick();
    bus.start_cnt = 1'b0;
    check("start_busy", TOT'(bus.busy), TOT'(c != 0));
    check("start_done", TOT'(bus.cnt_done), TOT'(c == 0));
    check("start_out", bus.out_final, model);
    for (int j = 1; j <= int'(c); j++) begin
      ren = rand_ren ? bit'($urandom_range(0, 1)) : 1'b1;
      bus.ring_en = ren;
      model = ring_step(model, ren);
      tick();
      check("run_out", bus.out_final, model);
      check("run_busy", TOT'(bus.busy), TOT'(j < int'(c)));
      check("run_done", TOT'(bus.cnt_done), TOT'(j == int'(c)));
    end
    bus.ring_en = 1'b1;
  endtask

  initial begin
    bus.load = 1'b0;
    bus.seed_top = '0;
    bus.cnt_load = 1'b0;
    bus.cycle = '0;
    bus.start_cnt = 1'b0;
    bus.ring_en = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out", bus.out_final, '0);
    check("rst_busy", TOT'(bus.busy), '0);
    check("rst_done", TOT'(bus.cnt_done), '0);

    // start_cnt in IDLE does nothing
    bus.start_cnt = 1'b1;
    tick();
    bus.start_cnt = 1'b0;
    tick();
    check("idle_start_out", bus.out_final, '0);
    check("idle_start_busy", TOT'(bus.busy), '0);
    check("idle_start_done", TOT'(bus.cnt_done), '0);

    // All segments = 1, one step, ring on
    set_cycle(1);
    do_load({4{32'h0000_0001}});
    run(1, 1'b0);
    check("ones_step", bus.out_final, {4{32'h0000_0002}});

    // MSB-set segment 0 couples into segment 1
    do_load({32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001});
    run(1, 1'b0);
    check("ring_on", bus.out_final,
          {32'h0000_0001, 32'h0000_0003, 32'h0000_0002, 32'h0000_0002});
    do_load({32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001});
    bus.ring_en = 1'b0;
    bus.start_cnt = 1'b1;
    tick();
    bus.start_cnt = 1'b0;
    tick();
    bus.ring_en = 1'b1;
    check("ring_off_seg1", TOT'(bus.out_final[95:64]), TOT'(32'h0000_0002));
    check("ring_off_done", TOT'(bus.cnt_done), TOT'(1));

    // Zero seed guard and zero-length run
    do_load('0);
    check("zero_guard", bus.out_final, {4{32'h0000_0001}});
    set_cycle(0);
    run(0, 1'b0);
    check("zero_run_out", bus.out_final, {4{32'h0000_0001}});

    // Abort a 100-step run with load at step 40; cnt_load mid-run ignored
    set_cycle(100);
    seed_a = rand_seed();
    do_load(seed_a);
    bus.start_cnt = 1'b1;
    tick();
    bus.start_cnt = 1'b0;
    for (int j = 1; j < 40; j++) begin
      if (j == 20) begin
        bus.cycle = CNT_W'(5);
        bus.cnt_load = 1'b1;
      end
      model = ring_step(model, 1'b1);
      tick();
      bus.cnt_load = 1'b0;
      check("abort_run_out", bus.out_final, model);
    end
    seed_b = rand_seed();
    seed_b[127:96] = '0;
    bus.seed_top = seed_b;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    model = seed_val(seed_b);
    check("abort_busy", TOT'(bus.busy), '0);
    check("abort_done", TOT'(bus.cnt_done), '0);
    check("abort_out", bus.out_final, model);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("abort_no_done", TOT'(bus.cnt_done), '0);
    end
    run(100, 1'b1);

    // 10 + 10 from DONE equals a single 20-step run
    seed_a = rand_seed();
    set_cycle(10);
    do_load(seed_a);
    run(10, 1'b0);
    run(10, 1'b0);
    res_split = model;
    set_cycle(20);
    do_load(seed_a);
    run(20, 1'b0);
    check("split_vs_whole", bus.out_final, res_split);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
